sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO; successor to the fixed 8x8 fifo in the memory-designs set.
//   Adds width/depth parameters, occupancy count, programmable almost-full/almost-empty flags,
//   overflow/underflow error pulses and legal same-cycle read+write at full.
//   Sits between a producer and consumer in the same clock domain as the shared buffering block.
// PARAMETERS
//   DATA_WIDTH    8   word width in bits (>=1)
//   DEPTH         16  number of entries; power of two, >=2
//   AFULL_THRESH  14  almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
//   AEMPTY_THRESH 2   almost_empty asserts when count <= AEMPTY_THRESH (0..DEPTH-1)
//   ADDR_W (localparam) = clog2(DEPTH)
// PORTS
//   clk          in   1            rising-edge clock, single domain
//   rst          in   1            synchronous, active-high reset
//   w_en         in   1            write request
//   r_en         in   1            read request
//   data_in      in   DATA_WIDTH   write data, sampled when write accepted
//   data_out     out  DATA_WIDTH   read data
//   full         out  1            count == DEPTH
//   empty        out  1            count == 0
//   almost_full  out  1            count >= AFULL_THRESH
//   almost_empty out  1            count <= AEMPTY_THRESH
//   count        out  ADDR_W+1     current occupancy, 0..DEPTH
//   overflow     out  1            1-cycle pulse: write rejected
//   underflow    out  1            1-cycle pulse: read rejected
// BEHAVIOUR
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, data_out=0, empty=1, almost_empty=1,
//     full=0, almost_full=0, overflow=underflow=0. Memory contents not reset. Reset wins over w_en/r_en.
//   - rd_ok = r_en & ~empty;  wr_ok = w_en & (~full | rd_ok)  (write at full legal only with a read).
//   - wr_ok: mem[wr_ptr]<=data_in, wr_ptr+1. rd_ok: rd_ptr+1. Pointers ADDR_W bits, wrap DEPTH-1 -> 0.
//   - count next = count + wr_ok - rd_ok; both -> unchanged. All flags decoded from registered count.
//   - Standard mode: rd_ok at edge N -> data_out = mem[rd_ptr] after edge N (1-cycle latency);
//     data_out holds its value when no read is accepted.
//   - overflow <= w_en & ~wr_ok; underflow <= r_en & ~rd_ok; both are registered, valid cycle after request.
//   - Empty + w_en + r_en: write accepted, read rejected (underflow pulses), count becomes 1.
//   - Full + w_en + r_en: both accepted, count stays DEPTH, full stays 1, no overflow.
//   - Reset mid-burst: queue discarded, next cycle behaves exactly as after power-on reset.
// CONFIGURATION
//   FIFO_FWFT_EN defined: first-word-fall-through; data_out = mem[rd_ptr] whenever ~empty
//     (head word visible the cycle after its write lands), r_en pops it; data_out = 0 when empty.
//   FIFO_FWFT_EN undefined: standard 1-cycle registered read as above. Flags/count identical in both.
// STRUCTURE
//   - Package fifo_pkg: clog2 function, threshold range checks, default width/depth constants.
//   - Sub-module fifo_mem_2p: DEPTH x DATA_WIDTH register array, sync write port, async read port
//     (read address rd_ptr); top holds pointers, count, flags, output register / FWFT mux.
// TESTING (DATA_WIDTH=8, DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=1)
//   1 Reset then write A5,5A,3C,C3 -> count 4, empty 0; 4 reads -> data_out A5,5A,3C,C3 in order, empty 1.
//   2 Write 8 words 00..07 -> almost_full at count 6, full at 8; 9th write -> overflow 1 cycle, count 8.
//   3 At full, w_en=r_en=1 with data 08 for 8 cycles -> full held, no overflow, reads 00..07 then 08.
//   4 Read when empty -> underflow 1 cycle, data_out unchanged, count 0; w_en+r_en on empty -> count 1.
//   5 Write 3 words, assert rst mid-burst -> next cycle count 0, empty 1, data_out 0, flags cleared.
//   6 Run test 1 with FIFO_FWFT_EN -> A5 on data_out before first r_en; each pop shows next word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
// Optional feature macro: FIFO_FWFT_EN (first-word-fall-through read port).
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  // Returns the number of bits needed to address v entries.
  // Loop is bounded so the function stays elaboration-friendly.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Depth must be a power of two (>=2). The almost-full threshold must be
  // reachable (1..depth). The almost-empty threshold must leave full
  // distinguishable (0..depth-1).
  function automatic bit fifo_cfg_ok(input int depth, input int af, input int ae);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem_2p #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

  // Write port: one word per accepted write.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags and overflow/underflow error pulses.
// Define FIFO_FWFT_EN for a first-word-fall-through read port. Otherwise
// the read data is registered with one cycle of latency.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH    = FIFO_DEF_WIDTH,
  parameter  int DEPTH         = FIFO_DEF_DEPTH,
  parameter  int AFULL_THRESH  = 14,
  parameter  int AEMPTY_THRESH = 2,
  localparam int ADDR_W        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int  CNT_W  = ADDR_W + 1;
  localparam bit  CFG_OK = fifo_cfg_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH);

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  ovf_q, unf_q;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  // All flags come from the registered count, so they are glitch-free.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AFULL_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AEMPTY_THRESH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Accept logic. A write at full is legal only when a read frees a slot
  // in the same cycle.
  always_comb begin
    rd_ok    = r_en & ~empty;
    wr_ok    = w_en & (~full | rd_ok);
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_ok);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_ok);
    count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
  end

  // Pointer, count and error-pulse state. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= w_en & ~wr_ok;
      unf_q    <= r_en & ~rd_ok;
    end
  end

  // Reset must win over a concurrent write, so gate the memory enable with rst.
  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_ok & ~rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

`ifdef FIFO_FWFT_EN
  // Head word is shown combinationally. An empty FIFO drives zeros.
  assign data_out = empty ? '0 : rd_data;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  // Registered read: capture the head word on an accepted read, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst)        dout_q <= '0;
    else if (rd_ok) dout_q <= rd_data;
  end

  assign data_out = dout_q;
`endif

  // Catch illegal parameter combinations in simulation.
  always_ff @(posedge clk) begin
    if (rst) assert (CFG_OK) else $error("sync_fifo_param: illegal DEPTH/threshold parameters");
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=8, AFULL=6, AEMPTY=1).
// A queue scoreboard holds the words written and is popped on accepted reads.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0, r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            e_ovf = 1'b0, e_unf = 1'b0;

  sync_fifo_param #(
    .DATA_WIDTH    (DW),
    .DEPTH         (D),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .r_en         (r_en),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Expected data_out from the scoreboard state.
  function automatic logic [DW-1:0] exp_data();
`ifdef FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  // Drive one cycle of w/r, then update the model after the edge.
  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
    bit rok, wok;
    rok = r && (q.size() != 0);
    wok = w && ((q.size() < D) || rok);
    w_en = w; r_en = r; data_in = d;
    @(posedge clk); #1;
    if (rok) m_dout = q.pop_front();
    if (wok) q.push_back(d);
    e_ovf = w && !wok;
    e_unf = r && !rok;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); m_dout = '0; e_ovf = 1'b0; e_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({count, empty, almost_empty, full, almost_full, overflow, underflow, data_out} !==
        {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b do=%h required cnt=0 e=1 ae=1 f=0 af=0 ov=0 un=0 do=00",
               count, empty, almost_empty, full, almost_full, overflow, underflow, data_out);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [4];
    vals[0] = 8'hA5; vals[1] = 8'h5A; vals[2] = 8'h3C; vals[3] = 8'hC3;
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, vals[i]);
    n_checks++;
    if (count !== 4'd4 || empty !== 1'b0) begin
      n_fail++; $display("FAIL basic_fill: count=%0d empty=%b required 4 0", count, empty);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'h00);
      n_checks++;
      if (data_out !== exp_data()) begin
        n_fail++; $display("FAIL basic_read%0d: data_out=%h required %h", i, data_out, exp_data());
      end
`ifndef FIFO_FWFT_EN
      n_checks++;
      if (data_out !== vals[i]) begin
        n_fail++; $display("FAIL basic_order%0d: data_out=%h required %h", i, data_out, vals[i]);
      end
`endif
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      n_fail++; $display("FAIL basic_drained: empty=%b count=%0d required 1 0", empty, count);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < D; i++) begin
      drive(1, 0, 8'(i));
      n_checks++;
      if (int'(count) !== i + 1 || almost_full !== (i + 1 >= AF) || full !== (i == D - 1) ||
          almost_empty !== (i + 1 <= AE)) begin
        n_fail++;
        $display("FAIL fill%0d: count=%0d af=%b f=%b ae=%b required %0d %b %b %b",
                 i, count, almost_full, full, almost_empty, i + 1, (i + 1 >= AF), (i == D - 1), (i + 1 <= AE));
      end
    end
    drive(1, 0, 8'hFF);
    n_checks++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
      n_fail++; $display("FAIL overflow_pulse: ov=%b count=%0d full=%b required 1 8 1", overflow, count, full);
    end
    drive(0, 0, 8'h00);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL overflow_clear: ov=%b required 0", overflow);
    end
  endtask

  // Continues from the full FIFO left by test_fill.
  task automatic test_full_rw();
    for (int i = 0; i < D; i++) begin
      drive(1, 1, 8'h08);
      n_checks++;
      if (full !== 1'b1 || overflow !== 1'b0 || count !== 4'd8 || data_out !== exp_data()) begin
        n_fail++;
        $display("FAIL full_rw%0d: f=%b ov=%b count=%0d do=%h required 1 0 8 %h",
                 i, full, overflow, count, data_out, exp_data());
      end
`ifndef FIFO_FWFT_EN
      n_checks++;
      if (data_out !== 8'(i)) begin
        n_fail++; $display("FAIL full_rw_order%0d: do=%h required %h", i, data_out, 8'(i));
      end
`endif
    end
    drive(0, 1, 8'h00);
    n_checks++;
    if (data_out !== exp_data() || count !== 4'd7) begin
      n_fail++; $display("FAIL full_rw_tail: do=%h count=%0d required %h 7", data_out, count, exp_data());
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < D && q.size() != 0; i++) drive(0, 1, 8'h00);
    drive(0, 1, 8'h00);
    n_checks++;
    if (underflow !== 1'b1 || count !== 4'd0 || data_out !== exp_data() || e_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_pulse: un=%b count=%0d do=%h required 1 0 %h", underflow, count, data_out, exp_data());
    end
    drive(1, 1, 8'h77);
    n_checks++;
    if (count !== 4'd1 || underflow !== 1'b1 || overflow !== 1'b0 || data_out !== exp_data()) begin
      n_fail++;
      $display("FAIL empty_rw: count=%0d un=%b ov=%b do=%h required 1 1 0 %h",
               count, underflow, overflow, data_out, exp_data());
    end
    drive(0, 0, 8'h00);
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fail++; $display("FAIL underflow_clear: un=%b required 0", underflow);
    end
    drive(0, 1, 8'h00);
    n_checks++;
    if (data_out !== exp_data() || empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_rw_read: do=%h empty=%b required %h 1", data_out, empty, exp_data());
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    drive(1, 0, 8'h11);
    drive(1, 0, 8'h22);
    drive(1, 1, 8'h33);
    rst = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'h44;
    @(posedge clk); #1;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    q.delete(); m_dout = '0;
    n_checks++;
    if ({count, empty, almost_empty, full, almost_full, overflow, underflow, data_out} !==
        {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL midburst_reset: cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b do=%h required cleared state",
               count, empty, almost_empty, full, almost_full, overflow, underflow, data_out);
    end
    drive(1, 0, 8'h55);
    drive(0, 1, 8'h00);
    n_checks++;
    if (data_out !== exp_data() || exp_data() !== 8'h55 || empty !== 1'b1) begin
      n_fail++; $display("FAIL midburst_after: do=%h empty=%b required 55 1", data_out, empty);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      n_checks++;
      if (int'(count) !== q.size() || data_out !== exp_data() || overflow !== e_ovf ||
          underflow !== e_unf || empty !== (q.size() == 0) || full !== (q.size() == D)) begin
        n_fail++; errs++;
        if (errs < 5)
          $display("FAIL random%0d: count=%0d do=%h ov=%b un=%b required %0d %h %b %b",
                   i, count, data_out, overflow, underflow, q.size(), exp_data(), e_ovf, e_unf);
      end
    end
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    do_reset();
    drive(1, 0, 8'hA5);
    n_checks++;
    if (data_out !== 8'hA5) begin
      n_fail++; $display("FAIL fwft_head: do=%h required a5", data_out);
    end
    drive(1, 0, 8'h5A);
    drive(0, 1, 8'h00);
    n_checks++;
    if (data_out !== 8'h5A) begin
      n_fail++; $display("FAIL fwft_pop: do=%h required 5a", data_out);
    end
    drive(0, 1, 8'h00);
    n_checks++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      n_fail++; $display("FAIL fwft_empty: do=%h empty=%b required 00 1", data_out, empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_rw();
    test_underflow();
    test_reset_midburst();
    test_random();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
